mem_store_ctrl: RTL and testbench
=================================

MEM_STORE_CTRL -- requirements
Module: mem_store_ctrl

Interface
REQ-001 Parameter: DATA_W, 16, data bus width.
REQ-002 Parameter: ADDR_W, 16, address bus width.
REQ-003 Parameter: TIMEOUT, 15, max WRITE-state cycles awaiting Mem_Ack (legal range 1..255).
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 Port: clk  input  1  rising-edge clock.
REQ-006 Port: reset  input  1  synchronous active-high reset.
REQ-007 Port: Store_req  input  1  store request from control unit.
REQ-008 Port: AR_in  input  ADDR_W  target address.
REQ-009 Port: MDR_in  input  DATA_W  data word to store.
REQ-010 Port: Store_ready  output  1  high when a request can be accepted.
REQ-011 Port: Mem_Addr_Bus  output  ADDR_W  address to data memory.
REQ-012 Port: Mem_Data_Out  output  DATA_W  write data to data memory.
REQ-013 Port: Mem_Wr_En  output  1  memory write strobe.
REQ-014 Port: Mem_Ack  input  1  memory write acknowledge.
REQ-015 Port: Store_done  output  1  one-cycle pulse, store completed.
REQ-016 Port: Store_err  output  1  one-cycle pulse, store timed out.

Function
REQ-017 FSM states SHALL be IDLE, SETUP, WRITE, DONE; all outputs registered.
REQ-018 Store_ready SHALL be 1 only in IDLE.
REQ-019 IDLE: Store_req=1 sampled at an edge SHALL capture AR_in/MDR_in into Mem_Addr_Bus/Mem_Data_Out and move to SETUP; Store_req=0 stays IDLE.
REQ-020 SETUP: exactly one cycle, Mem_Wr_En=0, buses stable; then WRITE.
REQ-021 WRITE: Mem_Wr_En=1; wait counter clears on WRITE entry and increments each WRITE cycle.
REQ-022 WRITE: Mem_Ack=1 SHALL move to DONE with completion status OK.
REQ-023 WRITE: if no Mem_Ack in TIMEOUT consecutive WRITE cycles, SHALL move to DONE with status ERR.
REQ-024 Mem_Ack and timeout in same cycle: Mem_Ack wins (status OK).
REQ-025 DONE: one cycle, Mem_Wr_En=0; Store_done=1 if OK, else Store_err=1; never both; then IDLE.
REQ-026 Mem_Ack SHALL be ignored in IDLE, SETUP, DONE.
REQ-027 Store_req outside IDLE SHALL be ignored (not queued); AR_in/MDR_in changes after capture SHALL NOT affect buses.
REQ-028 Mem_Addr_Bus/Mem_Data_Out SHALL hold last captured values through IDLE until next acceptance.
REQ-029 Latency: request accepted at edge N -> SETUP in cycle N+1, Mem_Wr_En=1 from cycle N+2, with ack in first WRITE cycle Store_done=1 in cycle N+3, Store_ready=1 in cycle N+4.
REQ-030 Back-to-back: Store_req held high SHALL be accepted on the first IDLE edge after DONE (minimum 4-cycle issue interval).

Reset
REQ-031 reset=1 at an edge SHALL force IDLE, counter=0, Mem_Addr_Bus=0, Mem_Data_Out=0, Mem_Wr_En=0, Store_done=0, Store_err=0, Store_ready=1 in the next cycle.
REQ-032 reset SHALL override Store_req and Mem_Ack in the same cycle, and SHALL abort any in-progress store with no done/err pulse.

Verification
REQ-033 Basic store: AR_in=0x0040, MDR_in=0xBEEF, Store_req 1 cycle, Mem_Ack on first WRITE cycle -> buses 0x0040/0xBEEF, Mem_Wr_En high 1 cycle, Store_done pulse 3 cycles after accept.
REQ-034 Delayed ack: Mem_Ack asserted in 5th WRITE cycle -> Mem_Wr_En high exactly 5 cycles, one Store_done, Store_err=0.
REQ-035 Timeout: TIMEOUT=15, Mem_Ack never -> Mem_Wr_En high 15 cycles, one Store_err pulse, Store_done=0, then Store_ready=1.
REQ-036 Ack on timeout cycle: Mem_Ack only in 15th WRITE cycle -> Store_done=1, Store_err=0.
REQ-037 Busy/ignored: second Store_req with AR_in=0x1234 during WRITE -> buses keep first values, no extra store; held Store_req after DONE -> accepted next IDLE edge.
REQ-038 Reset mid-store: reset during WRITE -> next cycle Mem_Wr_En=0, buses 0, Store_ready=1, no Store_done/Store_err pulse.

Source files
------------

// File: rtl/mem_store_ctrl.sv
// Single-word store sequencer to data memory: IDLE -> SETUP -> WRITE -> DONE.
// Latency: accept edge N, write strobe from N+2, done/err pulse one cycle after ack or timeout.
// Backpressure: Store_ready is low while busy; requests seen while busy are dropped, not queued.
module mem_store_ctrl #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Store_req,
    input  logic [ADDR_W-1:0] AR_in,
    input  logic [DATA_W-1:0] MDR_in,
    output logic              Store_ready,
    output logic [ADDR_W-1:0] Mem_Addr_Bus,
    output logic [DATA_W-1:0] Mem_Data_Out,
    output logic              Mem_Wr_En,
    input  logic              Mem_Ack,
    output logic              Store_done,
    output logic              Store_err
);

    typedef enum logic [1:0] {IDLE, SETUP, WRITE, DONE} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t     state, next_state;
    logic [7:0] wait_cnt, wait_cnt_d;
    logic       ok_d;

    always_comb begin
        next_state = state;
        wait_cnt_d = wait_cnt;
        ok_d       = 1'b0;
        case (state)
            IDLE: begin
                if (Store_req) next_state = SETUP;
            end
            SETUP: begin
                next_state = WRITE;
                wait_cnt_d = 8'd0;
            end
            WRITE: begin
                wait_cnt_d = wait_cnt + 8'd1;
                // Ack takes priority over an expiring wait window.
                if (Mem_Ack) begin
                    next_state = DONE;
                    ok_d       = 1'b1;
                end else if (wait_cnt == LAST_WAIT) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wait_cnt     <= 8'd0;
            Mem_Addr_Bus <= '0;
            Mem_Data_Out <= '0;
            Mem_Wr_En    <= 1'b0;
            Store_ready  <= 1'b1;
            Store_done   <= 1'b0;
            Store_err    <= 1'b0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_cnt_d;
            if (state == IDLE && Store_req) begin
                Mem_Addr_Bus <= AR_in;
                Mem_Data_Out <= MDR_in;
            end
            Mem_Wr_En   <= (next_state == WRITE);
            Store_ready <= (next_state == IDLE);
            Store_done  <= (next_state == DONE) && ok_d;
            Store_err   <= (next_state == DONE) && !ok_d;
        end
    end

endmodule

// File: tb/tb_mem_store_ctrl.sv
// Directed bench for mem_store_ctrl; stimulus pushes expected completions, a monitor pops and checks them.
module tb_mem_store_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Store_req = 1'b0;
    logic [15:0] AR_in = '0;
    logic [15:0] MDR_in = '0;
    logic        Store_ready;
    logic [15:0] Mem_Addr_Bus;
    logic [15:0] Mem_Data_Out;
    logic        Mem_Wr_En;
    logic        Mem_Ack = 1'b0;
    logic        Store_done;
    logic        Store_err;

    mem_store_ctrl #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .Store_req(Store_req), .AR_in(AR_in), .MDR_in(MDR_in),
        .Store_ready(Store_ready), .Mem_Addr_Bus(Mem_Addr_Bus), .Mem_Data_Out(Mem_Data_Out),
        .Mem_Wr_En(Mem_Wr_En), .Mem_Ack(Mem_Ack), .Store_done(Store_done), .Store_err(Store_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        bit          ok;
        int          wr;   // cycles Mem_Wr_En is high
        int          lat;  // cycles from SETUP to the done/err pulse
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor
    int   wr_cnt = 0;
    int   start_cyc = 0;
    bit   prev_rdy = 1'b1;
    bit   chk_rdy = 1'b0;
    exp_t e;
    always @(negedge clk) begin
        if (reset) begin
            wr_cnt  = 0;
            chk_rdy = 1'b0;
        end else begin
            if (chk_rdy) begin
                chk("ready_after_done", int'(Store_ready), 1);
                chk_rdy = 1'b0;
            end
            if (prev_rdy && !Store_ready) begin
                start_cyc = cyc;
                wr_cnt    = 0;
            end
            if (Mem_Wr_En) wr_cnt++;
            if (Store_done || Store_err) begin
                if (q.size() == 0) begin
                    chk("unexpected_completion", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("done_err_exclusive", int'(Store_done && Store_err), 0);
                    chk("done", int'(Store_done), int'(e.ok));
                    chk("err", int'(Store_err), int'(!e.ok));
                    chk("addr_bus", int'(Mem_Addr_Bus), int'(e.addr));
                    chk("data_bus", int'(Mem_Data_Out), int'(e.data));
                    chk("wr_en_cycles", wr_cnt, e.wr);
                    chk("latency", cyc - start_cyc, e.lat);
                end
                wr_cnt  = 0;
                chk_rdy = 1'b1;
            end
        end
        prev_rdy = Store_ready;
    end

    task automatic push(input logic [15:0] a, input logic [15:0] d, input bit ok, input int wr, input int lat);
        exp_t x;
        x.addr = a; x.data = d; x.ok = ok; x.wr = wr; x.lat = lat;
        q.push_back(x);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!Store_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!Store_ready) chk("ready_wait_timeout", 0, 1);
    endtask

    // Issue one store; ack in WRITE cycle k (0 = never), optionally also pulse ack during SETUP.
    task automatic store(input logic [15:0] a, input logic [15:0] d, input int k, input bit setup_ack);
        wait_ready();
        Store_req = 1'b1; AR_in = a; MDR_in = d;
        @(posedge clk); #1;
        Store_req = 1'b0;
        AR_in = ~a; MDR_in = ~d;
        Mem_Ack = setup_ack;
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1;
            Mem_Ack = 1'b0;
        end
        if (k > 0) begin
            Mem_Ack = 1'b1;
            @(posedge clk); #1;
        end
        Mem_Ack = 1'b0;
        @(posedge clk); #1;
        wait_ready();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", int'(Store_ready), 1);
        chk("rst_wr_en", int'(Mem_Wr_En), 0);
        chk("rst_addr", int'(Mem_Addr_Bus), 0);
        chk("rst_data", int'(Mem_Data_Out), 0);
        chk("rst_done", int'(Store_done), 0);
        chk("rst_err", int'(Store_err), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic store, ack in first WRITE cycle
        push(16'h0040, 16'hBEEF, 1'b1, 1, 2);
        store(16'h0040, 16'hBEEF, 1, 1'b0);
        chk("idle_hold_addr", int'(Mem_Addr_Bus), 16'h0040);

        // Ack in 5th WRITE cycle; an ack during SETUP is ignored
        push(16'h0102, 16'hA5A5, 1'b1, 5, 6);
        store(16'h0102, 16'hA5A5, 5, 1'b1);

        // No ack: timeout after 15 WRITE cycles
        push(16'h0203, 16'h1111, 1'b0, 15, 16);
        store(16'h0203, 16'h1111, 0, 1'b0);

        // Ack exactly on the 15th WRITE cycle wins over the timeout
        push(16'h0304, 16'h2222, 1'b1, 15, 16);
        store(16'h0304, 16'h2222, 15, 1'b0);

        // Second request during WRITE is dropped; buses keep first values
        push(16'h0400, 16'h3333, 1'b1, 3, 4);
        wait_ready();
        Store_req = 1'b1; AR_in = 16'h0400; MDR_in = 16'h3333;
        @(posedge clk); #1;
        Store_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        Store_req = 1'b1; AR_in = 16'h1234; MDR_in = 16'h5555;
        @(posedge clk); #1;
        Store_req = 1'b0;
        Mem_Ack = 1'b1;
        @(posedge clk); #1;
        Mem_Ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        wait_ready();

        // Held request with ack held high: two back-to-back stores, 4 cycles apart
        push(16'h0500, 16'h4444, 1'b1, 1, 2);
        push(16'h0600, 16'h6666, 1'b1, 1, 2);
        Store_req = 1'b1; Mem_Ack = 1'b1; AR_in = 16'h0500; MDR_in = 16'h4444;
        @(posedge clk); #1;
        AR_in = 16'h0600; MDR_in = 16'h6666;
        repeat (4) @(posedge clk);
        #1;
        Store_req = 1'b0; AR_in = 16'hFFFF; MDR_in = 16'hFFFF;
        repeat (4) @(posedge clk);
        #1;
        Mem_Ack = 1'b0;
        wait_ready();

        // Reset during WRITE aborts with no pulse
        Store_req = 1'b1; AR_in = 16'h0777; MDR_in = 16'h8888;
        @(posedge clk); #1;
        Store_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_wr_en", int'(Mem_Wr_En), 1);
        reset = 1'b1; Store_req = 1'b1; Mem_Ack = 1'b1;
        @(posedge clk); #1;
        chk("abort_wr_en", int'(Mem_Wr_En), 0);
        chk("abort_addr", int'(Mem_Addr_Bus), 0);
        chk("abort_data", int'(Mem_Data_Out), 0);
        chk("abort_ready", int'(Store_ready), 1);
        chk("abort_done", int'(Store_done), 0);
        chk("abort_err", int'(Store_err), 0);
        @(negedge clk); #1;
        reset = 1'b0; Store_req = 1'b0; Mem_Ack = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("ready_at_end", int'(Store_ready), 1);
        chk("pending_expected", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got=running want=finished");
        $fatal(1, "bench timeout");
    end

endmodule
